// File: rtl/complex_mem_stage.sv
// complex_mem_stage: forwards ALU results or runs a req/ack load/store with timeout abort
module complex_mem_stage #(
    parameter int NUMBER_SIZE   = 8,
    parameter int REG_ADDR_SIZE = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_kind,
    input  logic [NUMBER_SIZE-1:0]     in_res1,
    input  logic [NUMBER_SIZE-1:0]     in_res2,
    input  logic [NUMBER_SIZE-1:0]     in_st1,
    input  logic [NUMBER_SIZE-1:0]     in_st2,
    input  logic [REG_ADDR_SIZE-1:0]   in_rd,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [2*NUMBER_SIZE-1:0]   mem_addr,
    output logic [2*NUMBER_SIZE-1:0]   mem_wdata,
    input  logic                       mem_ack,
    input  logic [2*NUMBER_SIZE-1:0]   mem_rdata,
    output logic                       wb_valid,
    output logic [REG_ADDR_SIZE-1:0]   wb_rd,
    output logic [NUMBER_SIZE-1:0]     wb_data1,
    output logic [NUMBER_SIZE-1:0]     wb_data2,
    output logic                       mem_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, MEM} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [REG_ADDR_SIZE-1:0] rd_q;

    assign in_ready = (state == IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data1  <= '0;
            wb_data2  <= '0;
            mem_err   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && in_kind == 2'b00) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= in_rd;
                    wb_data1 <= in_res1;
                    wb_data2 <= in_res2;
                end else if (in_valid && (in_kind[0] ^ in_kind[1])) begin
                    state     <= MEM;
                    cnt       <= '0;
                    rd_q      <= in_rd;
                    mem_req   <= 1'b1;
                    mem_we    <= in_kind[1];
                    mem_addr  <= {in_res1, in_res2};
                    mem_wdata <= {in_st1, in_st2};
                end
            end else if (mem_ack || cnt == TLAST) begin
                // ack beats a coinciding timeout; timed-out loads write back zero
                state    <= IDLE;
                mem_req  <= 1'b0;
                mem_err  <= ~mem_ack;
                wb_valid <= ~mem_we;
                wb_rd    <= rd_q;
                wb_data1 <= mem_ack ? mem_rdata[2*NUMBER_SIZE-1:NUMBER_SIZE] : '0;
                wb_data2 <= mem_ack ? mem_rdata[NUMBER_SIZE-1:0] : '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_complex_mem_stage.sv
// tb_complex_mem_stage: randomized transaction-level check of complex_mem_stage with TIMEOUT=4
module tb_complex_mem_stage;
    localparam int T = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [1:0]  in_kind = 0;
    logic [7:0]  in_res1 = 0, in_res2 = 0, in_st1 = 0, in_st2 = 0;
    logic [3:0]  in_rd = 0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 0;
    logic [15:0] mem_rdata = 0;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [7:0]  wb_data1, wb_data2;
    logic        mem_err;

    int ncmp = 0;
    int nbad = 0;

    complex_mem_stage #(.NUMBER_SIZE(8), .REG_ADDR_SIZE(4), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_res1(in_res1), .in_res2(in_res2), .in_st1(in_st1), .in_st2(in_st2), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data1(wb_data1), .wb_data2(wb_data2), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_wb"}, wb_valid, 0);
        chk({tag, "_err"}, mem_err, 0);
    endtask

    // Issue one op; ack arrives in MEM cycle `dly` (never, if dly > T); rdata returned on ack.
    task automatic do_op(input logic [1:0] kind, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [7:0] s1, input logic [7:0] s2, input logic [3:0] rd,
                         input int dly, input logic [15:0] rdata);
        int  n;
        bit  tmo;
        chk("accept_ready", in_ready, 1);
        in_valid = 1; in_kind = kind; in_res1 = r1; in_res2 = r2;
        in_st1 = s1; in_st2 = s2; in_rd = rd;
        tick();
        in_valid = 0;
        in_res1 = 8'($urandom); in_res2 = 8'($urandom); in_rd = 4'($urandom);
        if (kind == 2'b00) begin
            chk("pass_wb", wb_valid, 1);
            chk("pass_rd", wb_rd, rd);
            chk("pass_d1", wb_data1, r1);
            chk("pass_d2", wb_data2, r2);
            chk("pass_req", mem_req, 0);
        end else if (kind == 2'b11) begin
            chk_quiet("rsv");
            chk("rsv_ready", in_ready, 1);
        end else begin
            tmo = dly > T;
            n = tmo ? T : dly;
            for (int c = 1; c <= n; c++) begin
                chk("mem_req", mem_req, 1);
                chk("mem_ready", in_ready, 0);
                chk("mem_addr", mem_addr, {r1, r2});
                chk("mem_we", mem_we, kind == 2'b10);
                if (kind == 2'b10) chk("mem_wdata", mem_wdata, {s1, s2});
                chk("mem_wb", wb_valid, 0);
                mem_ack = (c == dly);
                mem_rdata = (c == dly) ? rdata : 16'($urandom);
                tick();
                mem_ack = 0;
            end
            chk("done_req", mem_req, 0);
            chk("done_ready", in_ready, 1);
            chk("done_err", mem_err, tmo);
            chk("done_wb", wb_valid, kind == 2'b01);
            if (kind == 2'b01) begin
                chk("done_rd", wb_rd, rd);
                chk("done_data", {wb_data1, wb_data2}, tmo ? 16'h0 : rdata);
            end
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_outs", {mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data1, wb_data2, mem_err}, 0);
        rst = 0;
        #1;
        chk("post_rst_ready", in_ready, 1);

        do_op(2'b00, 8'h12, 8'h34, 0, 0, 4'd3, 0, 0);
        do_op(2'b00, 8'h01, 8'h02, 0, 0, 4'd1, 0, 0);
        do_op(2'b00, 8'h03, 8'h04, 0, 0, 4'd2, 0, 0);
        do_op(2'b00, 8'h05, 8'h06, 0, 0, 4'd5, 0, 0);
        do_op(2'b01, 8'h01, 8'hF0, 0, 0, 4'd7, 3, 16'hA55A);
        do_op(2'b10, 8'h00, 8'h80, 8'h7F, 8'h81, 4'd2, 1, 16'hFFFF);
        do_op(2'b01, 8'h22, 8'h33, 0, 0, 4'd9, T + 1, 16'h1234);
        do_op(2'b01, 8'h22, 8'h33, 0, 0, 4'd9, T, 16'hBEEF);
        do_op(2'b10, 8'h44, 8'h55, 8'h66, 8'h77, 4'd4, T + 2, 16'h0);

        // reset abandons an outstanding load
        in_valid = 1; in_kind = 2'b01; in_res1 = 8'hC0; in_res2 = 8'hDE; in_rd = 4'd6;
        tick();
        in_valid = 0;
        chk("mid_req", mem_req, 1);
        rst = 1;
        tick();
        chk_quiet("mid_rst");
        chk("mid_rst_ready", in_ready, 0);
        rst = 0;
        mem_ack = 1; mem_rdata = 16'h5555;
        tick();
        chk_quiet("stray_ack1");
        tick();
        mem_ack = 0;
        chk_quiet("stray_ack2");
        chk("stray_ready", in_ready, 1);
        do_op(2'b11, 8'h99, 8'h88, 0, 0, 4'd8, 0, 0);

        for (int i = 0; i < 80; i++)
            do_op(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  4'($urandom), int'($urandom_range(1, T + 2)), 16'($urandom));
        tick();
        chk_quiet("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
